// File: rtl/reorder_buffer_pkg.sv
// Shared types and helpers for the reorder buffer: architectural widths,
// per-entry destination metadata and the retire-count helper.
package reorder_buffer_pkg;

  localparam int ARF_SEL    = 5;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic               wb;
    logic [ARF_SEL-1:0] rd;
  } rob_meta_t;

  function automatic logic [1:0] retire_count(input logic valid_1, input logic valid_2);
    return {1'b0, valid_1} + {1'b0, valid_2};
  endfunction

endpackage

// File: rtl/reorder_buffer_commit_sel.sv
// Two-slot head commit selection: slot 2 may only retire alongside slot 1,
// which keeps regfile writes strictly in program order.
module reorder_buffer_commit_sel #(
  parameter int ROB_DEPTH = 8,
  parameter int ROB_SEL   = 3
) (
  input  logic [ROB_DEPTH-1:0] busy,
  input  logic [ROB_DEPTH-1:0] done,
  input  logic [ROB_DEPTH-1:0] wb,
  input  logic [ROB_SEL-1:0]   head,
  input  logic                 flush,
  output logic                 valid_1,
  output logic                 valid_2,
  output logic                 wr_en_1,
  output logic                 wr_en_2,
  output logic [ROB_SEL-1:0]   idx_1,
  output logic [ROB_SEL-1:0]   idx_2
);

  // Head-pair readiness, suppressed while a flush is in progress
  always_comb begin
    idx_1   = head;
    idx_2   = head + ROB_SEL'(1);
    valid_1 = busy[idx_1] & done[idx_1] & ~flush;
    valid_2 = valid_1 & busy[idx_2] & done[idx_2];
    wr_en_1 = valid_1 & wb[idx_1];
    wr_en_2 = valid_2 & wb[idx_2];
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dual dispatch at the tail, dual completion by
// tag, dual in-order retirement from the head straight into the regfile ports.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH = 8,
  parameter int ROB_SEL   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_dp_en_1,
  input  logic                  i_dp_en_2,
  input  logic                  i_dp_wb_1,
  input  logic                  i_dp_wb_2,
  input  logic [ARF_SEL-1:0]    i_dp_rd_1,
  input  logic [ARF_SEL-1:0]    i_dp_rd_2,
  output logic [ROB_SEL-1:0]    o_dp_tag_1,
  output logic [ROB_SEL-1:0]    o_dp_tag_2,
  output logic                  o_dp_ready,
  input  logic                  i_cmp_en_1,
  input  logic                  i_cmp_en_2,
  input  logic [ROB_SEL-1:0]    i_cmp_tag_1,
  input  logic [ROB_SEL-1:0]    i_cmp_tag_2,
  input  logic [DATA_WIDTH-1:0] i_cmp_data_1,
  input  logic [DATA_WIDTH-1:0] i_cmp_data_2,
  output logic                  o_cm_valid_1,
  output logic                  o_cm_valid_2,
  output logic                  o_cm_wr_en_1,
  output logic                  o_cm_wr_en_2,
  output logic [ARF_SEL-1:0]    o_cm_addr_1,
  output logic [ARF_SEL-1:0]    o_cm_addr_2,
  output logic [DATA_WIDTH-1:0] o_cm_data_1,
  output logic [DATA_WIDTH-1:0] o_cm_data_2,
  output logic [ROB_SEL-1:0]    o_cm_tag_1,
  output logic [ROB_SEL-1:0]    o_cm_tag_2,
  output logic [ROB_SEL:0]      o_count
);

  localparam int CW = ROB_SEL + 1;

  logic [ROB_DEPTH-1:0]  busy_q, busy_d, done_q, done_d, wb_vec;
  rob_meta_t             meta_q [ROB_DEPTH];
  rob_meta_t             meta_d [ROB_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [ROB_DEPTH];
  logic [DATA_WIDTH-1:0] data_d [ROB_DEPTH];
  logic [ROB_SEL-1:0]    head_q, head_d, tail_q, tail_d, tail_p1;
  logic [CW-1:0]         count_q, count_d;
  logic                  dp_ready;
  logic [1:0]            n_disp, n_ret;
  logic                  cm_valid_1, cm_valid_2, cm_wr_en_1, cm_wr_en_2;
  logic [ROB_SEL-1:0]    cm_idx_1, cm_idx_2;

  // Dispatch acceptance and write-back flags gathered for commit selection
  always_comb begin
    tail_p1  = tail_q + ROB_SEL'(1);
    dp_ready = (count_q <= CW'(ROB_DEPTH - 2));
    if (dp_ready && i_dp_en_1) begin
      n_disp = i_dp_en_2 ? 2'd2 : 2'd1;
    end else begin
      n_disp = 2'd0;
    end
    for (int i = 0; i < ROB_DEPTH; i++) begin
      wb_vec[i] = meta_q[i].wb;
    end
  end

  reorder_buffer_commit_sel #(
    .ROB_DEPTH (ROB_DEPTH),
    .ROB_SEL   (ROB_SEL)
  ) u_commit_sel (
    .busy    (busy_q),
    .done    (done_q),
    .wb      (wb_vec),
    .head    (head_q),
    .flush   (i_flush),
    .valid_1 (cm_valid_1),
    .valid_2 (cm_valid_2),
    .wr_en_1 (cm_wr_en_1),
    .wr_en_2 (cm_wr_en_2),
    .idx_1   (cm_idx_1),
    .idx_2   (cm_idx_2)
  );

  assign n_ret = retire_count(cm_valid_1, cm_valid_2);

  // Next state: completion, then retire-clear, then allocation; flush overrides all
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    meta_d  = meta_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Port 2 is applied last so it wins when both ports carry the same tag
      if (i_cmp_en_1 && busy_q[i_cmp_tag_1]) begin
        done_d[i_cmp_tag_1] = 1'b1;
        data_d[i_cmp_tag_1] = i_cmp_data_1;
      end
      if (i_cmp_en_2 && busy_q[i_cmp_tag_2]) begin
        done_d[i_cmp_tag_2] = 1'b1;
        data_d[i_cmp_tag_2] = i_cmp_data_2;
      end
      if (cm_valid_1) begin
        busy_d[cm_idx_1] = 1'b0;
        done_d[cm_idx_1] = 1'b0;
      end
      if (cm_valid_2) begin
        busy_d[cm_idx_2] = 1'b0;
        done_d[cm_idx_2] = 1'b0;
      end
      if (n_disp != 2'd0) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        meta_d[tail_q] = '{wb: i_dp_wb_1, rd: i_dp_rd_1};
      end
      if (n_disp == 2'd2) begin
        busy_d[tail_p1] = 1'b1;
        done_d[tail_p1] = 1'b0;
        meta_d[tail_p1] = '{wb: i_dp_wb_2, rd: i_dp_rd_2};
      end
      head_d  = head_q + ROB_SEL'(n_ret);
      tail_d  = tail_q + ROB_SEL'(n_disp);
      count_d = count_q + CW'(n_disp) - CW'(n_ret);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        meta_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      meta_q  <= meta_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_dp_ready   = dp_ready;
  assign o_dp_tag_1   = tail_q;
  assign o_dp_tag_2   = tail_p1;
  assign o_count      = count_q;
  assign o_cm_valid_1 = cm_valid_1;
  assign o_cm_valid_2 = cm_valid_2;
  assign o_cm_wr_en_1 = cm_wr_en_1;
  assign o_cm_wr_en_2 = cm_wr_en_2;
  // Payload is held at zero on idle slots so the regfile ports never see stale data
  assign o_cm_addr_1  = cm_valid_1 ? meta_q[cm_idx_1].rd : '0;
  assign o_cm_addr_2  = cm_valid_2 ? meta_q[cm_idx_2].rd : '0;
  assign o_cm_data_1  = cm_valid_1 ? data_q[cm_idx_1] : '0;
  assign o_cm_data_2  = cm_valid_2 ? data_q[cm_idx_2] : '0;
  assign o_cm_tag_1   = cm_valid_1 ? cm_idx_1 : '0;
  assign o_cm_tag_2   = cm_valid_2 ? cm_idx_2 : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table plus random
// traffic, both compared against a program-order queue model.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, i_flush;
  logic        i_dp_en_1, i_dp_en_2, i_dp_wb_1, i_dp_wb_2;
  logic [4:0]  i_dp_rd_1, i_dp_rd_2;
  logic [2:0]  o_dp_tag_1, o_dp_tag_2;
  logic        o_dp_ready;
  logic        i_cmp_en_1, i_cmp_en_2;
  logic [2:0]  i_cmp_tag_1, i_cmp_tag_2;
  logic [31:0] i_cmp_data_1, i_cmp_data_2;
  logic        o_cm_valid_1, o_cm_valid_2, o_cm_wr_en_1, o_cm_wr_en_2;
  logic [4:0]  o_cm_addr_1, o_cm_addr_2;
  logic [31:0] o_cm_data_1, o_cm_data_2;
  logic [2:0]  o_cm_tag_1, o_cm_tag_2;
  logic [3:0]  o_count;

  reorder_buffer #(.ROB_DEPTH(8), .ROB_SEL(3)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_dp_en_1(i_dp_en_1), .i_dp_en_2(i_dp_en_2),
    .i_dp_wb_1(i_dp_wb_1), .i_dp_wb_2(i_dp_wb_2),
    .i_dp_rd_1(i_dp_rd_1), .i_dp_rd_2(i_dp_rd_2),
    .o_dp_tag_1(o_dp_tag_1), .o_dp_tag_2(o_dp_tag_2), .o_dp_ready(o_dp_ready),
    .i_cmp_en_1(i_cmp_en_1), .i_cmp_en_2(i_cmp_en_2),
    .i_cmp_tag_1(i_cmp_tag_1), .i_cmp_tag_2(i_cmp_tag_2),
    .i_cmp_data_1(i_cmp_data_1), .i_cmp_data_2(i_cmp_data_2),
    .o_cm_valid_1(o_cm_valid_1), .o_cm_valid_2(o_cm_valid_2),
    .o_cm_wr_en_1(o_cm_wr_en_1), .o_cm_wr_en_2(o_cm_wr_en_2),
    .o_cm_addr_1(o_cm_addr_1), .o_cm_addr_2(o_cm_addr_2),
    .o_cm_data_1(o_cm_data_1), .o_cm_data_2(o_cm_data_2),
    .o_cm_tag_1(o_cm_tag_1), .o_cm_tag_2(o_cm_tag_2),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, de1, de2, wb1, wb2;
    logic [4:0]  rd1, rd2;
    logic        ce1, ce2;
    logic [2:0]  ct1, ct2;
    logic [31:0] cd1, cd2;
  } in_t;

  typedef struct {
    in_t         in;
    logic [3:0]  cnt;
    logic        rdy;
    logic [2:0]  tag1;
    logic        v1, v2, we1, we2;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2;
  } vec_t;

  typedef struct {
    int          tag;
    logic        wb;
    logic [4:0]  rd;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  logic [31:0] rf [32];
  logic        e_v1, e_v2;
  int          total = 0;
  int          bad = 0;
  vec_t        vt [30];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic in_t none();
    in_t r;
    r.fl = 1'b0; r.de1 = 1'b0; r.de2 = 1'b0; r.wb1 = 1'b0; r.wb2 = 1'b0;
    r.rd1 = 5'd0; r.rd2 = 5'd0; r.ce1 = 1'b0; r.ce2 = 1'b0;
    r.ct1 = 3'd0; r.ct2 = 3'd0; r.cd1 = 32'd0; r.cd2 = 32'd0;
    return r;
  endfunction

  function automatic in_t dsp(logic e2, logic w1, int r1, logic w2, int r2);
    in_t r = none();
    r.de1 = 1'b1; r.de2 = e2; r.wb1 = w1; r.wb2 = w2;
    r.rd1 = 5'(r1); r.rd2 = 5'(r2);
    return r;
  endfunction

  function automatic in_t cmp(logic e1, int t1, logic [31:0] d1, logic e2, int t2, logic [31:0] d2);
    in_t r = none();
    r.ce1 = e1; r.ct1 = 3'(t1); r.cd1 = d1;
    r.ce2 = e2; r.ct2 = 3'(t2); r.cd2 = d2;
    return r;
  endfunction

  function automatic vec_t mv(in_t i, int cnt, logic rdy, int tag1, logic v1, logic v2,
                              logic we1, logic we2, int a1, int a2, logic [31:0] d1, logic [31:0] d2);
    vec_t r;
    r.in = i; r.cnt = 4'(cnt); r.rdy = rdy; r.tag1 = 3'(tag1);
    r.v1 = v1; r.v2 = v2; r.we1 = we1; r.we2 = we2;
    r.a1 = 5'(a1); r.a2 = 5'(a2); r.d1 = d1; r.d2 = d2;
    return r;
  endfunction

  task automatic apply(input in_t s);
    i_flush = s.fl; i_dp_en_1 = s.de1; i_dp_en_2 = s.de2;
    i_dp_wb_1 = s.wb1; i_dp_wb_2 = s.wb2; i_dp_rd_1 = s.rd1; i_dp_rd_2 = s.rd2;
    i_cmp_en_1 = s.ce1; i_cmp_en_2 = s.ce2; i_cmp_tag_1 = s.ct1; i_cmp_tag_2 = s.ct2;
    i_cmp_data_1 = s.cd1; i_cmp_data_2 = s.cd2;
  endtask

  // Expected outputs come from the program-order queue, not from DUT state
  task automatic model_check(input in_t s);
    int sz = mq.size();
    e_v1 = 1'b0;
    e_v2 = 1'b0;
    if (!s.fl && sz > 0) e_v1 = mq[0].done;
    if (e_v1 && sz > 1) e_v2 = mq[1].done;
    chk("m.count", 32'(o_count), 32'(sz));
    chk("m.ready", 32'(o_dp_ready), 32'((8 - sz) >= 2));
    chk("m.tag1", 32'(o_dp_tag_1), 32'(m_tail));
    chk("m.tag2", 32'(o_dp_tag_2), 32'((m_tail + 1) % 8));
    chk("m.v1", 32'(o_cm_valid_1), 32'(e_v1));
    chk("m.v2", 32'(o_cm_valid_2), 32'(e_v2));
    chk("m.we1", 32'(o_cm_wr_en_1), 32'(e_v1 && mq[0].wb));
    chk("m.we2", 32'(o_cm_wr_en_2), 32'(e_v2 && mq[1].wb));
    if (e_v1) begin
      chk("m.addr1", 32'(o_cm_addr_1), 32'(mq[0].rd));
      chk("m.data1", o_cm_data_1, mq[0].data);
      chk("m.cmtag1", 32'(o_cm_tag_1), 32'(mq[0].tag));
    end
    if (e_v2) begin
      chk("m.addr2", 32'(o_cm_addr_2), 32'(mq[1].rd));
      chk("m.data2", o_cm_data_2, mq[1].data);
      chk("m.cmtag2", 32'(o_cm_tag_2), 32'(mq[1].tag));
    end
  endtask

  task automatic model_step(input in_t s);
    int   pre = mq.size();
    ent_t e;
    if (s.fl) begin
      mq.delete();
      m_tail = 0;
    end else begin
      if (e_v1) void'(mq.pop_front());
      if (e_v2) void'(mq.pop_front());
      for (int i = 0; i < mq.size(); i++)
        if (s.ce1 && mq[i].tag == int'(s.ct1)) begin mq[i].done = 1'b1; mq[i].data = s.cd1; end
      for (int i = 0; i < mq.size(); i++)
        if (s.ce2 && mq[i].tag == int'(s.ct2)) begin mq[i].done = 1'b1; mq[i].data = s.cd2; end
      if ((8 - pre) >= 2 && s.de1) begin
        e.tag = m_tail; e.wb = s.wb1; e.rd = s.rd1; e.done = 1'b0; e.data = 32'd0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % 8;
        if (s.de2) begin
          e.tag = m_tail; e.wb = s.wb2; e.rd = s.rd2;
          mq.push_back(e);
          m_tail = (m_tail + 1) % 8;
        end
      end
    end
  endtask

  task automatic cycle(input in_t s, input bit has_exp, input vec_t ev, input int k);
    logic [2:0] t2;
    @(negedge clk);
    apply(s);
    #1;
    model_check(s);
    if (has_exp) begin
      t2 = ev.tag1 + 3'd1;
      chk($sformatf("v%0d.cnt", k), 32'(o_count), 32'(ev.cnt));
      chk($sformatf("v%0d.rdy", k), 32'(o_dp_ready), 32'(ev.rdy));
      chk($sformatf("v%0d.tag1", k), 32'(o_dp_tag_1), 32'(ev.tag1));
      chk($sformatf("v%0d.tag2", k), 32'(o_dp_tag_2), 32'(t2));
      chk($sformatf("v%0d.v1", k), 32'(o_cm_valid_1), 32'(ev.v1));
      chk($sformatf("v%0d.v2", k), 32'(o_cm_valid_2), 32'(ev.v2));
      chk($sformatf("v%0d.we1", k), 32'(o_cm_wr_en_1), 32'(ev.we1));
      chk($sformatf("v%0d.we2", k), 32'(o_cm_wr_en_2), 32'(ev.we2));
      if (ev.v1) begin
        chk($sformatf("v%0d.a1", k), 32'(o_cm_addr_1), 32'(ev.a1));
        chk($sformatf("v%0d.d1", k), o_cm_data_1, ev.d1);
      end
      if (ev.v2) begin
        chk($sformatf("v%0d.a2", k), 32'(o_cm_addr_2), 32'(ev.a2));
        chk($sformatf("v%0d.d2", k), o_cm_data_2, ev.d2);
      end
    end
    if (o_cm_wr_en_1) rf[o_cm_addr_1] = o_cm_data_1;
    if (o_cm_wr_en_2) rf[o_cm_addr_2] = o_cm_data_2;
    model_step(s);
  endtask

  initial begin
    in_t  s;
    vec_t dummy;

    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    mq.delete();
    m_tail = 0;
    dummy = mv(none(), 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0, 32'd0);

    vt[0]  = mv(dsp(1'b1, 1'b1, 5, 1'b1, 6), 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[1]  = mv(cmp(1'b1, 0, 32'hA, 1'b1, 1, 32'hB), 2, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[2]  = mv(none(), 2, 1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 5, 6, 32'hA, 32'hB);
    vt[3]  = mv(none(), 0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[4]  = mv(dsp(1'b1, 1'b1, 7, 1'b1, 8), 0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[5]  = mv(cmp(1'b1, 3, 32'h33, 1'b0, 0, 32'h0), 2, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[6]  = mv(cmp(1'b1, 2, 32'h22, 1'b0, 0, 32'h0), 2, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[7]  = mv(none(), 2, 1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b1, 7, 8, 32'h22, 32'h33);
    vt[8]  = mv(none(), 0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[9]  = mv(dsp(1'b0, 1'b0, 9, 1'b0, 0), 0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[10] = mv(cmp(1'b1, 4, 32'h44, 1'b0, 0, 32'h0), 1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[11] = mv(none(), 1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 9, 0, 32'h44, 32'h0);
    vt[12] = mv(none(), 0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[13] = mv(dsp(1'b1, 1'b1, 3, 1'b1, 3), 0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[14] = mv(cmp(1'b1, 5, 32'h1, 1'b1, 6, 32'h2), 2, 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[15] = mv(none(), 2, 1'b1, 7, 1'b1, 1'b1, 1'b1, 1'b1, 3, 3, 32'h1, 32'h2);
    vt[16] = mv(none(), 0, 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[17] = mv(dsp(1'b1, 1'b1, 10, 1'b1, 11), 0, 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[18] = mv(dsp(1'b1, 1'b1, 12, 1'b1, 13), 2, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[19] = mv(dsp(1'b1, 1'b1, 14, 1'b1, 15), 4, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[20] = mv(dsp(1'b1, 1'b1, 16, 1'b1, 17), 6, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[21] = mv(dsp(1'b1, 1'b1, 18, 1'b1, 19), 8, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[22] = mv(cmp(1'b1, 7, 32'h70, 1'b1, 0, 32'h71), 8, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[23] = mv(none(), 8, 1'b0, 7, 1'b1, 1'b1, 1'b1, 1'b1, 10, 11, 32'h70, 32'h71);
    vt[24] = mv(dsp(1'b0, 1'b1, 20, 1'b0, 0), 6, 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[25] = mv(cmp(1'b1, 1, 32'h55, 1'b0, 0, 32'h0), 7, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    s = dsp(1'b1, 1'b1, 21, 1'b1, 22);
    s.fl = 1'b1; s.ce1 = 1'b1; s.ct1 = 3'd2; s.cd1 = 32'h66;
    vt[26] = mv(s, 7, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[27] = mv(dsp(1'b0, 1'b1, 23, 1'b0, 0), 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    vt[28] = mv(none(), 1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
    s = none();
    s.fl = 1'b1;
    vt[29] = mv(s, 1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);

    apply(none());
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.count", 32'(o_count), 32'd0);
    chk("rst.ready", 32'(o_dp_ready), 32'd1);
    chk("rst.tag1", 32'(o_dp_tag_1), 32'd0);
    chk("rst.tag2", 32'(o_dp_tag_2), 32'd1);
    chk("rst.cm", 32'({o_cm_valid_1, o_cm_valid_2, o_cm_wr_en_1, o_cm_wr_en_2}), 32'd0);
    chk("rst.cmdata", o_cm_data_1 | o_cm_data_2, 32'd0);

    for (int k = 0; k < 30; k++) cycle(vt[k].in, 1'b1, vt[k], k);
    chk("rf.x3", rf[3], 32'h2);
    chk("rf.x5", rf[5], 32'hA);

    for (int n = 0; n < 600; n++) begin
      s = none();
      s.fl  = ($urandom_range(0, 39) == 0);
      s.de1 = ($urandom_range(0, 2) != 0);
      s.de2 = 1'($urandom_range(0, 1));
      s.wb1 = 1'($urandom_range(0, 1));
      s.wb2 = 1'($urandom_range(0, 1));
      s.rd1 = 5'($urandom_range(0, 31));
      s.rd2 = 5'($urandom_range(0, 31));
      s.ce1 = 1'($urandom_range(0, 1));
      s.ce2 = 1'($urandom_range(0, 1));
      s.ct1 = 3'($urandom_range(0, 7));
      s.ct2 = 3'($urandom_range(0, 7));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) s.ct1 = 3'(mq[$urandom_range(0, mq.size() - 1)].tag);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) s.ct2 = 3'(mq[$urandom_range(0, mq.size() - 1)].tag);
      s.cd1 = $urandom;
      s.cd2 = $urandom;
      cycle(s, 1'b0, dummy, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the dual-issue core. Allocates up to two entries per cycle at dispatch, marks entries done from two completion ports, and retires up to two done entries per cycle from the head. Commit outputs drive the architectural register file's two write ports directly, so results reach architectural state strictly in program order.

## Interface
Parameters:
- ROB_DEPTH, 8, number of entries; power of two, at least 4
- ROB_SEL, 3, log2(ROB_DEPTH); tag width

Ports:
- clk  in  1  core clock
- rst  in  1  reset; **synchronous, active-high, single clock domain (clk)**
- i_flush  in  1  discard all entries (mispredict/exception)
- i_dp_en_1 / i_dp_en_2  in  1  dispatch request, slot 1 / slot 2 (slot 2 only valid with slot 1)
- i_dp_wb_1 / i_dp_wb_2  in  1  instruction writes a destination register
- i_dp_rd_1 / i_dp_rd_2  in  `RV32_ARF_SEL  destination architectural register
- o_dp_tag_1 / o_dp_tag_2  out  ROB_SEL  tag assigned to slot 1 (= tail) / slot 2 (= tail+1)
- o_dp_ready  out  1  at least two free entries
- i_cmp_en_1 / i_cmp_en_2  in  1  completion valid
- i_cmp_tag_1 / i_cmp_tag_2  in  ROB_SEL  completing entry
- i_cmp_data_1 / i_cmp_data_2  in  `RV32_DATA_WIDTH  result
- o_cm_valid_1 / o_cm_valid_2  out  1  entry retires this cycle
- o_cm_wr_en_1 / o_cm_wr_en_2  out  1  retire with register write (to regfile write enable)
- o_cm_addr_1 / o_cm_addr_2  out  `RV32_ARF_SEL  regfile write address
- o_cm_data_1 / o_cm_data_2  out  `RV32_DATA_WIDTH  regfile write data
- o_cm_tag_1 / o_cm_tag_2  out  ROB_SEL  retiring tag (rename table release)
- o_count  out  ROB_SEL+1  occupied entries

## Operation
- State: per entry busy, done, wb, rd, data; head, tail (ROB_SEL bits, wrap modulo ROB_DEPTH); count.
- Dispatch: accepted only when o_dp_ready; slot 1 written at tail, slot 2 at tail+1; tail += number accepted. Requests while !o_dp_ready dropped; i_dp_en_2 without i_dp_en_1 ignored.
- Completion: sets done, stores data. Completion to a non-busy entry ignored. Both ports same tag: port 2 wins.
- Commit (combinational from registered state): o_cm_valid_1 = busy[head] & done[head]; o_cm_valid_2 = o_cm_valid_1 & busy[head+1] & done[head+1]. o_cm_wr_en_n = o_cm_valid_n & wb. At the edge, retired entries cleared, head += retired.
- Same rd on both commit slots: both wr_en asserted; regfile port 2 ordering yields slot 2 value, which is program-correct.
- count_next = count + dispatched − retired; o_dp_ready = (ROB_DEPTH − count) >= 2, from registered count.
- Flush: head, tail, count to 0, all busy/done cleared; overrides dispatch, completion and commit that cycle; o_cm_valid/wr_en forced 0 while i_flush high.
- No constraint on entries freed this cycle: they become allocatable next cycle.

## Timing
- Reset values: head=tail=count=0, busy/done 0, o_dp_ready=1, o_dp_tag_1=0, o_dp_tag_2=1, all o_cm_* 0, o_count=0. Reset dominates flush.
- Dispatch-to-commit minimum 2 cycles: dispatch at edge N, completion at edge N+1 earliest, commit outputs during cycle N+1..N+2, regfile written at following edge.
- Completion-to-commit latency 1 cycle: done is registered; an entry completed at edge N is visible to commit after N.
- Full wrap: tail reaching head with count=ROB_DEPTH is full; count disambiguates full/empty.

## Structure
- ROB_DEPTH/ROB_SEL defines added to constants.vh beside `RV32_ARF_SEL and `RV32_DATA_WIDTH.
- Single module; per-entry storage as flat arrays, no sub-module. Optional sub-module rob_commit_sel (two-slot head-commit selection) if reused by LSU.

## Test plan
- Reset, dual dispatch rd=5,rd=6 wb=1 -> tags 0,1, o_count=2; complete both with 0xA,0xB -> next cycle o_cm_wr_en_1/2=1, addr 5/6, data 0xA/0xB; o_count=0 after.
- Out-of-order completion: complete tag 1 before tag 0 -> no commit until tag 0 done, then both retire same cycle.
- Fill 8 entries -> o_dp_ready=0 at count 7; dispatch attempt while full leaves o_count=8; retire 2 -> o_dp_ready=1; tail wraps to tag 0 correctly.
- wb=0 entry at head done -> o_cm_valid_1=1, o_cm_wr_en_1=0, head advances.
- Same rd=3 on both commit slots with 0x1,0x2 -> regfile x3=0x2.
- Flush with 5 entries, simultaneous dispatch and completion -> o_count=0, no commit, next dispatch gets tag 0.
